load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, single-beat memory handshake and a cycle timeout.
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] TMO_C = TIMEOUT[7:0];

    state_t      state_r;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic [7:0]  cnt_r;
    logic        ready_r;
    logic        mem_valid_r;
    logic        mem_we_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        req_ok_s;
    logic        misalign_s;
    logic        start_ok_s;
    logic        hit_s;
    logic        tmo_s;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halves only look at addr[1], words at neither address bit.
    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] lo;
        case (size)
            2'b00:   lo = off;
            2'b01:   lo = {off[1], 1'b0};
            default: lo = 2'b00;
        endcase
        return lo;
    endfunction

    function automatic logic [3:0] be_f(input logic we, input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        if (!we) begin
            be = 4'b1111;
        end else begin
            case (size)
                2'b00:   be = 4'b0001 << off;
                2'b01:   be = 4'b0011 << {off[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
        logic [31:0] lane;
        logic [31:0] res;
        lane = word >> {lane_off(f3[1:0], off), 3'b000};
        case (f3)
            3'b000:  res = {{24{lane[7]}}, lane[7:0]};
            3'b001:  res = {{16{lane[15]}}, lane[15:0]};
            3'b100:  res = {24'd0, lane[7:0]};
            3'b101:  res = {16'd0, lane[15:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    // Request legality plus the per-cycle handshake and timeout conditions
    always_comb begin
        req_ok_s   = f3_legal(req_we, req_funct3);
        misalign_s = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01) begin
            misalign_s = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misalign_s = |req_addr[1:0];
        end else begin
            misalign_s = 1'b0;
        end
`endif
        start_ok_s = req_ok_s & ~misalign_s;
        hit_s      = mem_valid_r & mem_ready;
        tmo_s      = (cnt_r + 8'd1) == TMO_C;
    end

    // Transaction FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            funct3_r    <= 3'd0;
            off_r       <= 2'd0;
            cnt_r       <= 8'd0;
            ready_r     <= 1'b1;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'd0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && ready_r) begin
                        we_r     <= req_we;
                        funct3_r <= req_funct3;
                        off_r    <= req_addr[1:0];
                        ready_r  <= 1'b0;
                        if (start_ok_s) begin
                            state_r     <= ISSUE;
                            cnt_r       <= 8'd0;
                            mem_valid_r <= 1'b1;
                            mem_we_r    <= req_we;
                            mem_be_r    <= be_f(req_we, req_funct3[1:0], req_addr[1:0]);
                            mem_addr_r  <= {req_addr[31:2], 2'b00};
                            mem_wdata_r <= req_we ? wdata_f(req_funct3[1:0], req_wdata) : 32'd0;
                        end else begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'd0;
                        end
                    end
                end
                ISSUE: begin
                    if (hit_s || tmo_s) begin
                        mem_valid_r <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_be_r    <= 4'd0;
                        mem_addr_r  <= 32'd0;
                        mem_wdata_r <= 32'd0;
                    end
                    // A store completes on acceptance; a load still needs its data beat.
                    if (hit_s && we_r) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= 32'd0;
                    end else if (tmo_s) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= 32'd0;
                    end else if (hit_s) begin
                        state_r <= WAIT;
                        cnt_r   <= cnt_r + 8'd1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= load_f(funct3_r, off_r, mem_rdata);
                    end else if (tmo_s) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    ready_r     <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= 32'd0;
                end
                default: begin
                    state_r     <= IDLE;
                    ready_r     <= 1'b1;
                    mem_valid_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= 32'd0;
                end
            endcase
        end
    end

    // ready_r sits at 1 through reset so acceptance resumes the first cycle rst is low.
    assign req_ready = ready_r & ~rst;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign mem_valid = mem_valid_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
